// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing one single-port synchronous SRAM between
// instruction fetch (m0) and load/store (m1); 1-cycle read latency.
module mem_bus_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic [AW-1:0]   m0_addr,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_be,
  input  logic            m1_lock,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic       lock_q;
  logic [3:0] starve_cnt;
  logic       rsp_vld_q;
  logic       rsp_m1_q;
  logic       rsp_we_q;
  logic       sel_m0;
  logic       sel_m1;

  // While locked, m1 keeps the memory and a waiting fetch cannot override.
  always_comb begin
    sel_m0 = 1'b0;
    sel_m1 = 1'b0;
    if (!rst) begin
      if (lock_q)
        sel_m1 = m1_req;
      else if (starve_cnt == LIMIT && m0_req)
        sel_m0 = 1'b1;
      else if (m1_req)
        sel_m1 = 1'b1;
      else if (m0_req)
        sel_m0 = 1'b1;
    end
  end

  assign m0_gnt    = sel_m0;
  assign m1_gnt    = sel_m1;
  assign mem_en    = sel_m0 | sel_m1;
  assign mem_we    = sel_m1 & m1_we;
  assign mem_addr  = sel_m1 ? m1_addr  : (sel_m0 ? m0_addr : '0);
  assign mem_wdata = sel_m1 ? m1_wdata : '0;
  assign mem_be    = sel_m1 ? m1_be    : (sel_m0 ? '1 : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= 1'b0;
      starve_cnt <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_m1_q   <= 1'b0;
      rsp_we_q   <= 1'b0;
    end else begin
      rsp_vld_q <= sel_m0 | sel_m1;
      rsp_m1_q  <= sel_m1;
      rsp_we_q  <= sel_m1 & m1_we;

      if (!m0_req || sel_m0)
        starve_cnt <= '0;
      else if (starve_cnt < LIMIT)
        starve_cnt <= starve_cnt + 4'd1;

      // An idle m1 cycle drops the lock so a stalled LSU cannot wedge fetch.
      if (!m1_req)
        lock_q <= 1'b0;
      else if (sel_m1)
        lock_q <= m1_lock;
    end
  end

  assign m0_rvalid = rsp_vld_q & ~rsp_m1_q;
  assign m1_rvalid = rsp_vld_q & rsp_m1_q;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = (m1_rvalid && !rsp_we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a rule-level reference model.
module tb_mem_bus_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [BW-1:0] m1_be;
  logic          m1_lock;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: how many cycles in a row the fetch has been refused,
  // whether m1 currently owns the memory, and responses due next cycle.
  int denied   = 0;
  bit locked   = 0;
  int rsp_q[$];      // 0 = m0 read, 1 = m1 read, 2 = m1 write
  bit e_g0, e_g1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic sample();
    int owner;
    @(negedge clk);
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (!rst) begin
      if (locked)                        e_g1 = m1_req;
      else if (denied >= LIMIT && m0_req) e_g0 = 1'b1;
      else if (m1_req)                   e_g1 = 1'b1;
      else if (m0_req)                   e_g0 = 1'b1;
    end
    check("m0_gnt", m0_gnt, e_g0);
    check("m1_gnt", m1_gnt, e_g1);
    check("mem_en", mem_en, e_g0 | e_g1);
    if (e_g1) begin
      check("mem_we", mem_we, m1_we);
      check("mem_addr", mem_addr, m1_addr);
      check("mem_wdata", mem_wdata, m1_wdata);
      check("mem_be", mem_be, m1_be);
    end else if (e_g0) begin
      check("mem_we", mem_we, 0);
      check("mem_addr", mem_addr, m0_addr);
      check("mem_be", mem_be, {BW{1'b1}});
    end else begin
      check("mem_we", mem_we, 0);
      check("mem_addr", mem_addr, 0);
      check("mem_wdata", mem_wdata, 0);
      check("mem_be", mem_be, 0);
    end
    owner = (rsp_q.size() > 0) ? rsp_q[0] : -1;
    check("m0_rvalid", m0_rvalid, owner == 0);
    check("m0_rdata", m0_rdata, (owner == 0) ? mem_rdata : 0);
    check("m1_rvalid", m1_rvalid, owner == 1 || owner == 2);
    check("m1_rdata", m1_rdata, (owner == 1) ? mem_rdata : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    rsp_q.delete();
    if (rst) begin
      denied = 0;
      locked = 0;
    end else begin
      if (e_g1)      rsp_q.push_back(m1_we ? 2 : 1);
      else if (e_g0) rsp_q.push_back(0);
      if (!m0_req || e_g0)  denied = 0;
      else if (denied < LIMIT) denied++;
      if (!m1_req)   locked = 0;
      else if (e_g1) locked = m1_lock;
    end
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m1_req = 0; m1_we = 0; m1_lock = 0;
    m0_addr = '0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
  endtask

  initial begin
    rst = 1;
    idle();
    mem_rdata = '0;

    // Reset with both masters requesting
    m0_req = 1; m1_req = 1; m0_addr = 32'h40; m1_addr = 32'h80;
    for (int i = 0; i < 2; i++) begin
      sample();
      check("rst_gnt", {m0_gnt, m1_gnt}, 2'b00);
      check("rst_mem_en", mem_en, 0);
      tick();
    end
    rst = 0;
    idle();
    sample();
    check("post_rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    check("post_rst_starve", dut.starve_cnt, 0);
    tick();

    // Single fetch
    m0_req = 1; m0_addr = 32'h100;
    sample();
    check("fetch_gnt", m0_gnt, 1);
    tick();
    idle();
    mem_rdata = 32'h0050_0093;
    sample();
    check("fetch_rdata", m0_rdata, 32'h0050_0093);
    check("fetch_m1_rvalid", m1_rvalid, 0);
    tick();

    // LSU write then read
    m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'hDEAD_BEEF; m1_be = 4'b0011;
    sample();
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_be", mem_be, 4'b0011);
    tick();
    m1_we = 0; m1_wdata = '0; m1_be = 4'b1111;
    mem_rdata = 32'h1234_5678;
    sample();
    check("wr_rsp", {m1_rvalid, m1_rdata}, {1'b1, 32'h0});
    tick();
    idle();
    mem_rdata = 32'hCAFE_F00D;
    sample();
    check("rd_rsp", {m1_rvalid, m1_rdata}, {1'b1, 32'hCAFE_F00D});
    tick();

    // Starvation: continuous contention gives m0 every fifth slot
    m0_req = 1; m0_addr = 32'h104; m1_req = 1; m1_addr = 32'h204; m1_be = 4'hF;
    for (int i = 0; i < 10; i++) begin
      sample();
      check("starve_m0_gnt", m0_gnt, (i % 5) == 4);
      tick();
    end
    idle();
    sample();
    tick();

    // Lock: reads under lock, unlocking write, then m0 overrides m1
    m0_req = 1; m0_addr = 32'h108;
    m1_req = 1; m1_addr = 32'h300; m1_be = 4'hF; m1_lock = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin m1_we = 1; m1_lock = 0; m1_wdata = 32'h5555_AAAA; end
      if (i == 5) begin m1_we = 0; m1_addr = 32'h304; end
      sample();
      check("lock_m0_gnt", m0_gnt, i == 5);
      tick();
    end
    idle();
    sample();
    tick();

    // Reset while locked
    m0_req = 1; m0_addr = 32'h10C;
    m1_req = 1; m1_addr = 32'h300; m1_be = 4'hF; m1_lock = 1;
    sample();
    check("rl_m1_gnt", m1_gnt, 1);
    tick();
    rst = 1;
    sample();
    tick();
    rst = 0; m1_req = 0; m1_lock = 0;
    sample();
    check("rl_m1_rvalid", m1_rvalid, 0);
    check("rl_lock", dut.lock_q, 0);
    check("rl_m0_gnt", m0_gnt, 1);
    tick();
    idle();

    // Randomized traffic; masters hold requests until granted
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(63) == 0);
      if (!m0_req || e_g0) begin
        m0_req  = ($urandom_range(2) != 0);
        m0_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!m1_req || e_g1) begin
        m1_req   = $urandom_range(1);
        m1_we    = $urandom_range(1);
        m1_addr  = $urandom();
        m1_wdata = $urandom();
        m1_be    = BW'($urandom());
        m1_lock  = ($urandom_range(2) == 0);
      end
      mem_rdata = $urandom();
      sample();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-master arbiter that shares one single-port synchronous SRAM between the tinyriscv instruction-fetch port (m0) and the load/store port (m1).
- Grants are decided in the same cycle as the request; the SRAM has 1-cycle read latency.
- Responses are routed back to the issuing master.
- m1 has priority; a starvation counter guarantees fetch progress; a lock input holds the memory for read-modify-write sequences.

Parameters:
AW, 32, address width
DW, 32, data width (multiple of 8)
STARVE_LIMIT, 4, consecutive denied m0 request cycles before m0 is forced to win (1..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
m0_req  input  1  fetch request
m0_addr  input  AW  fetch byte address
m0_gnt  output  1  fetch accepted this cycle (combinational)
m0_rvalid  output  1  fetch read data valid
m0_rdata  output  DW  fetch read data
m1_req  input  1  LSU request
m1_we  input  1  1 = write
m1_addr  input  AW  LSU byte address
m1_wdata  input  DW  write data
m1_be  input  DW/8  byte enables
m1_lock  input  1  hold memory after this access
m1_gnt  output  1  LSU accepted this cycle (combinational)
m1_rvalid  output  1  LSU response valid (reads and writes)
m1_rdata  output  DW  LSU read data (0 for writes)
mem_en  output  1  SRAM access enable
mem_we  output  1  SRAM write enable
mem_addr  output  AW  SRAM address
mem_wdata  output  DW  SRAM write data
mem_be  output  DW/8  SRAM byte enables
mem_rdata  input  DW  SRAM read data, valid the cycle after mem_en

Behaviour:
Handshake
- A transaction is accepted at the rising edge where req && gnt.
- A master holds req and its payload stable until gnt.
- At most one gnt is high per cycle.
- A new acceptance is allowed every cycle (fully pipelined).

Winner selection (combinational, in priority order)
1. lock_q=1: m1 wins if m1_req; m0_gnt=0 regardless.
2. starve_cnt==STARVE_LIMIT && m0_req: m0 wins.
3. m1_req: m1 wins.
4. m0_req: m0 wins.
5. Otherwise idle: mem_en=0, mem_we=0, mem_addr/mem_wdata/mem_be=0.

Memory drive
- mem_en = winner present.
- mem_* carries the winner's payload.
- For m0: mem_we=0 and mem_be all-ones.

Response
- Registered owner/valid: rsp_vld_q and rsp_m1_q, plus rsp_we_q.
- In the cycle after acceptance, the owner's rvalid=1.
- rdata = mem_rdata for reads; m1_rdata = 0 for m1 writes.
- The non-owner's rvalid=0 and rdata=0.
- Latency is exactly 1 cycle; back-to-back responses are allowed.

starve_cnt (4-bit)
- 0 when !m0_req or m0 granted.
- Otherwise increments by 1, saturating at STARVE_LIMIT.

lock_q
- Set at an m1 acceptance with m1_lock=1.
- Cleared at an m1 acceptance with m1_lock=0, or in any cycle with m1_req=0.
- While lock_q=1, starve_cnt keeps counting but does not override.

Reset
- All registers clear: rsp_vld_q=0, rsp_m1_q=0, starve_cnt=0, lock_q=0.
- All rvalid=0 and rdata=0 the cycle after rst.
- A transaction presented during a rst cycle produces no response.
- gnt is forced to 0 and mem_en to 0 while rst=1.
- Reset mid-lock releases the lock.

Simultaneous events
- When both masters request with starve_cnt < limit and no lock, m1 wins and starve_cnt increments.
- When starve_cnt==limit, m0 wins and m1 retries next cycle.

Test Plan:
- Reset: hold rst=1 for 2 cycles with both reqs high -> gnt=0, mem_en=0; after release, all rvalid=0 and starve_cnt=0.
- Single fetch: m0_req, addr=0x100, mem_rdata=0x00500093 next cycle -> m0_gnt same cycle, m0_rvalid=1 and m0_rdata=0x00500093 exactly one cycle later, m1_rvalid=0.
- LSU write then read: write 0xDEADBEEF, be=4'b0011, addr=0x200, then read 0x200 -> mem_we=1 and mem_be=0011 on the write cycle; m1_rvalid for both; m1_rdata=0 for the write and mem_rdata for the read.
- Starvation (STARVE_LIMIT=4): m0_req and m1_req held continuously -> m1 granted 4 cycles, m0 granted on the 5th, pattern repeats every 5 cycles.
- Lock: m1 read 0x300 with m1_lock=1, then write 0x300 with m1_lock=0, m0_req high throughout for 8 cycles -> m0_gnt=0 until after the write is accepted, then m0 granted the next cycle.
- Reset mid-operation: assert rst the cycle after an m1 read acceptance with lock_q=1 -> m1_rvalid=0 the next cycle, lock_q=0, m0 granted first after release.
